db_str_seq: RTL

DB_STR_SEQ -- requirements
Module: db_str_seq

---
 rtl/db_str_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/db_str_seq.sv
// db_str_seq: strong deblocking filter for one edge segment of LINE_NUM lines.
// Two clip3 units are shared over three cycles; define DB_STR_TC_ZERO_SKIP_EN to bypass filtering when tc==0.
module db_str_clip3 #(
   parameter int TC_W = 5
) (
   input  logic [10:0]     raw,
   input  logic [7:0]      x,
   input  logic [TC_W-1:0] tc,
   output logic [7:0]      o
);
   localparam int W = (TC_W + 2 > 11) ? TC_W + 2 : 11;
   logic [W-1:0] tc2, xw, rw, sum;
   logic [7:0] lo, hi;
   always_comb begin
      tc2 = W'(tc) << 1;
      xw  = W'(x);
      rw  = W'(raw);
      sum = xw + tc2;
      lo  = (xw < tc2) ? 8'd0 : x - tc2[7:0];
      hi  = (sum > W'(255)) ? 8'hff : sum[7:0];
      o   = (rw < W'(lo)) ? lo : (rw > W'(hi)) ? hi : raw[7:0];
   end
endmodule

module db_str_seq #(
   parameter  int LINE_NUM = 4,
   parameter  int TC_W     = 5,
   localparam int LW       = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [TC_W-1:0] tc_i,
   input  logic            line_valid_i,
   output logic            line_ready_o,
   input  logic [31:0]     p_i,
   input  logic [31:0]     q_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [23:0]     out_p_o,
   output logic [23:0]     out_q_o,
   output logic [LW-1:0]   out_line_o,
   output logic            busy_o,
   output logic            done_o
);
   typedef enum logic [2:0] {IDLE, WAIT_LINE, CLIP0, CLIP1, CLIP2, OUT} state_t;
   state_t state, state_nx;
   logic [TC_W-1:0] tc_r;
   logic [31:0] p_r, q_r;
   logic [LW-1:0] line_r;
   logic [1:0] sel;
   logic [7:0] xp, xq, cp, cq;
   logic [10:0] raw_p, raw_q;
   logic skip, line_hs, out_hs, last, clip;

   // a is the side being filtered, b the opposite side of the edge
   function automatic logic [10:0] raw_f(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
      logic [10:0] a0, a1, a2, a3, b0, b1, t0, t1, t2;
      a0 = {3'b0, a[7:0]};
      a1 = {3'b0, a[15:8]};
      a2 = {3'b0, a[23:16]};
      a3 = {3'b0, a[31:24]};
      b0 = {3'b0, b[7:0]};
      b1 = {3'b0, b[15:8]};
      t0 = (a2 + (a1 << 1) + (a0 << 1) + (b0 << 1) + b1 + 11'd4) >> 3;
      t1 = (a2 + a1 + a0 + b0 + 11'd2) >> 2;
      t2 = ((a3 << 1) + (a2 << 1) + a2 + a1 + a0 + b0 + 11'd4) >> 3;
      raw_f = (s == 2'd0) ? t0 : (s == 2'd1) ? t1 : t2;
   endfunction

   assign line_hs      = (state == WAIT_LINE) && line_valid_i;
   assign out_hs       = (state == OUT) && out_ready_i;
   assign last         = line_r == LW'(LINE_NUM - 1);
   assign clip         = (state == CLIP0) || (state == CLIP1) || (state == CLIP2);
   assign sel          = (state == CLIP1) ? 2'd1 : (state == CLIP2) ? 2'd2 : 2'd0;
   assign raw_p        = raw_f(sel, p_r, q_r);
   assign raw_q        = raw_f(sel, q_r, p_r);
   assign xp           = p_r[{sel, 3'b000} +: 8];
   assign xq           = q_r[{sel, 3'b000} +: 8];
   assign line_ready_o = state == WAIT_LINE;
   assign out_valid_o  = state == OUT;
   assign busy_o       = state != IDLE;
   assign out_line_o   = line_r;
`ifdef DB_STR_TC_ZERO_SKIP_EN
   assign skip = tc_r == '0;
`else
   assign skip = 1'b0;
`endif

   db_str_clip3 #(.TC_W(TC_W)) u_clip_p (.raw(raw_p), .x(xp), .tc(tc_r), .o(cp));
   db_str_clip3 #(.TC_W(TC_W)) u_clip_q (.raw(raw_q), .x(xq), .tc(tc_r), .o(cq));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = start_i ? WAIT_LINE : IDLE;
         WAIT_LINE: state_nx = line_valid_i ? (skip ? OUT : CLIP0) : WAIT_LINE;
         CLIP0:     state_nx = CLIP1;
         CLIP1:     state_nx = CLIP2;
         CLIP2:     state_nx = OUT;
         OUT:       state_nx = out_ready_i ? (last ? IDLE : WAIT_LINE) : OUT;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tc_r    <= '0;
         p_r     <= '0;
         q_r     <= '0;
         out_p_o <= '0;
         out_q_o <= '0;
         line_r  <= '0;
         done_o  <= 1'b0;
      end else begin
         state  <= state_nx;
         done_o <= out_hs && last;
         if (state == IDLE && start_i) tc_r <= tc_i;
         if (line_hs) begin
            p_r <= p_i;
            q_r <= q_i;
         end
         if (line_hs && skip) begin
            out_p_o <= p_i[23:0];
            out_q_o <= q_i[23:0];
         end
         if (clip) begin
            out_p_o[{sel, 3'b000} +: 8] <= cp;
            out_q_o[{sel, 3'b000} +: 8] <= cq;
         end
         if (out_hs) line_r <= last ? '0 : line_r + 1'b1;
      end
   end
endmodule
